// File: rtl/lab2_serial_carry_4_bit_add.sv
// rtl/lab2_serial_carry_4_bit_add.sv - bit-serial ripple adder, one bit per clock, LSB first (optional Ovf via LAB2_ADD_OVERFLOW_EN)
module lab2_serial_carry_4_bit_add #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] Sum,
    output logic         Cout,
    output logic         busy,
    output logic         done
`ifdef LAB2_ADD_OVERFLOW_EN
    ,
    output logic         Ovf
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    // a_q is both the A operand shifter and the result register: each
    // SHIFT cycle its LSB is consumed and the new sum bit enters its MSB.
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic          fa_s, fa_c;
    logic          load;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        load    = 1'b0;

        fa_s = a_q[0] ^ b_q[0] ^ carry_q;
        fa_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load = 1'b1;
                end
            end
            S_SHIFT: begin
                a_d     = {fa_s, a_q[N-1:1]};
                b_d     = {1'b0, b_q[N-1:1]};
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    sum_d   = {fa_s, a_q[N-1:1]};
                    cout_d  = fa_c;
                    // carry_q is the carry into the MSB on this last bit
                    ovf_d   = carry_q ^ fa_c;
                end
            end
            S_DONE: begin
                if (start) begin
                    load = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            state_d = S_SHIFT;
            a_d     = A;
            b_d     = B;
            carry_d = Cin;
            cnt_d   = '0;
        end

        busy_d = (state_d == S_SHIFT);
        done_d = (state_d == S_DONE);
    end

    // State register with synchronous reset overriding start
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef LAB2_ADD_OVERFLOW_EN
    assign Ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_lab2_serial_carry_4_bit_add.sv
// tb/tb_lab2_serial_carry_4_bit_add.sv - directed scoreboard bench for the serial adder
module tb_lab2_serial_carry_4_bit_add;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [3:0] Sum;
    logic       Cout;
    logic       busy;
    logic       done;
`ifdef LAB2_ADD_OVERFLOW_EN
    logic       Ovf;
`endif

    lab2_serial_carry_4_bit_add #(.N(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Sum   (Sum),
        .Cout  (Cout),
        .busy  (busy),
        .done  (done)
`ifdef LAB2_ADD_OVERFLOW_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] s;
        logic       c;
        logic       v;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] a, input logic [3:0] b, input logic cin);
        logic [4:0] full;
        logic [3:0] low;
        exp_t       e;
        full = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        low  = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b0, cin};
        e.s  = full[3:0];
        e.c  = full[4];
        e.v  = low[3] ^ full[4];
        sb.push_back(e);
    endtask

    task automatic start_op(input logic [3:0] a, input logic [3:0] b, input logic cin,
                            input bit expect_result);
        A     = a;
        B     = b;
        Cin   = cin;
        start = 1'b1;
        if (expect_result) push_exp(a, b, cin);
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int edges_done);
        int   lat;
        exp_t e;
        lat = 0;
        for (int k = edges_done + 1; k <= 12; k++) begin
            tick();
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            chk({tag, "_busy"}, 32'(busy), 32'd1);
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else if (lat != 0) begin
            e = sb.pop_front();
            chk({tag, "_sum"}, 32'(Sum), 32'(e.s));
            chk({tag, "_cout"}, 32'(Cout), 32'(e.c));
`ifdef LAB2_ADD_OVERFLOW_EN
            chk({tag, "_ovf"}, 32'(Ovf), 32'(e.v));
`endif
        end
    endtask

    initial begin
        int   seen_done;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        Cin   = 1'b0;

        tick();
        tick();
        chk("rst_sum", 32'(Sum), 32'd0);
        chk("rst_cout", 32'(Cout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
`ifdef LAB2_ADD_OVERFLOW_EN
        chk("rst_ovf", 32'(Ovf), 32'd0);
`endif
        rst = 1'b0;
        tick();

        start_op(4'b0110, 4'b0101, 1'b1, 1'b1);
        wait_done("op_6_5_1", 0);
        tick();

        start_op(4'b1000, 4'b1101, 1'b0, 1'b1);
        wait_done("op_8_d_0", 0);
        tick();
        tick();
        chk("hold_sum", 32'(Sum), 32'h5);
        chk("hold_cout", 32'(Cout), 32'd1);
        chk("hold_done", 32'(done), 32'd0);

        start_op(4'b0111, 4'b0110, 1'b0, 1'b1);
        wait_done("op_7_6_0", 0);
        tick();

        start_op(4'b1111, 4'b0000, 1'b1, 1'b1);
        wait_done("op_wrap", 0);
        tick();

        // start held and A changing during SHIFT must not disturb the captured op
        start_op(4'b0011, 4'b0001, 1'b0, 1'b1);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            A   = 4'($urandom);
            B   = 4'($urandom);
            Cin = 1'($urandom);
            tick();
            chk("ignore_start_busy", 32'(busy), 32'd1);
        end
        start = 1'b0;
        wait_done("op_held_start", 3);
        // back-to-back start in the DONE cycle
        start_op(4'b0000, 4'b0000, 1'b1, 1'b1);
        wait_done("op_b2b", 0);
        tick();

        // abort in the 2nd SHIFT cycle
        start_op(4'b1001, 4'b1001, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_sum", 32'(Sum), 32'd0);
        chk("abort_cout", 32'(Cout), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done === 1'b1) seen_done++;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        chk("abort_idle_busy", 32'(busy), 32'd0);

        start_op(4'b0010, 4'b0111, 1'b1, 1'b1);
        wait_done("op_after_abort", 0);
        tick();

        // reset wins over start on the same edge
        rst   = 1'b1;
        start = 1'b1;
        A     = 4'b0101;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", 32'(busy), 32'd0);
        chk("rst_start_sum", 32'(Sum), 32'd0);
        tick();
        chk("rst_start_idle", 32'(busy), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
